shl_iter: RTL and testbench

Multicycle logical left shifter for the RISC processor's execution unit. It is the left-direction counterpart of the combinational arithmetic right shifter. It takes a 32-bit operand and a 32-bit shift amount, decomposes the amount into five power-of-two stages, and applies one stage per clock. This keeps the datapath to a single 32-bit 2:1 mux level per cycle. A start/busy/done handshake makes it usable as a fixed-latency functional unit under control-FSM sequencing.

---
 rtl/shl_iter.sv | 151 +++++++++++++++
 tb/tb_shl_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shl_iter.sv
// shl_iter: multicycle logical left shifter.
// A 32-bit operand is shifted left by a 32-bit unsigned amount, one
// power-of-two stage (1, 2, 4, 8, 16) per clock, so each cycle needs only
// a single 2:1 mux level. Latency is a fixed 6 clocks from the accepting
// edge to the result edge.
// Optional feature: define SHL_OVF_FLAG_EN to add the ovf output, which
// flags any 1 bit shifted out of the top of the word.
// Handshake: start is accepted on a rising edge only while busy is low;
// done pulses for one cycle with shifted valid, and busy is already low in
// that cycle, so a back-to-back start is accepted there. A start while
// busy is high is dropped without indication.
module shl_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] shift,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shifted,
`ifdef SHL_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] amt_q;
  logic [2:0]       stg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] shifted_q;
  logic [WIDTH-1:0] acc_d;
  logic             large_shift;

`ifdef SHL_OVF_FLAG_EN
  logic             sticky_q;
  logic             nz_q;
  logic             ovf_q;
  logic             spill_d;
`endif

  // Any amount bit above the five stage bits means a shift of 32 or more.
  assign large_shift = |amt_q[WIDTH-1:5];

  // One stage of the shift network: conditional shift by 2^stg.
  always_comb begin
    acc_d = acc_q;
    case (stg_q)
      3'd0:    if (amt_q[0]) acc_d = {acc_q[WIDTH-2:0],  1'b0};
      3'd1:    if (amt_q[1]) acc_d = {acc_q[WIDTH-3:0],  2'b0};
      3'd2:    if (amt_q[2]) acc_d = {acc_q[WIDTH-5:0],  4'b0};
      3'd3:    if (amt_q[3]) acc_d = {acc_q[WIDTH-9:0],  8'b0};
      3'd4:    if (amt_q[4]) acc_d = {acc_q[WIDTH-17:0], 16'b0};
      default: acc_d = acc_q;
    endcase
  end

`ifdef SHL_OVF_FLAG_EN
  // Bits that fall off the top in the current stage, if the stage is active.
  always_comb begin
    spill_d = 1'b0;
    case (stg_q)
      3'd0:    spill_d = amt_q[0] & acc_q[WIDTH-1];
      3'd1:    spill_d = amt_q[1] & (|acc_q[WIDTH-1:WIDTH-2]);
      3'd2:    spill_d = amt_q[2] & (|acc_q[WIDTH-1:WIDTH-4]);
      3'd3:    spill_d = amt_q[3] & (|acc_q[WIDTH-1:WIDTH-8]);
      3'd4:    spill_d = amt_q[4] & (|acc_q[WIDTH-1:WIDTH-16]);
      default: spill_d = 1'b0;
    endcase
  end
`endif

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      amt_q     <= '0;
      stg_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shifted_q <= '0;
`ifdef SHL_OVF_FLAG_EN
      sticky_q  <= 1'b0;
      nz_q      <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q    <= input1;
            amt_q    <= shift;
            stg_q    <= 3'd0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
`ifdef SHL_OVF_FLAG_EN
            sticky_q <= 1'b0;
            nz_q     <= |input1;
`endif
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
`ifdef SHL_OVF_FLAG_EN
          sticky_q <= sticky_q | spill_d;
`endif
          // stg stays at 4 on the last stage rather than wrapping past it.
          if (stg_q == 3'd4) begin
            state_q <= S_FIN;
          end else begin
            stg_q <= stg_q + 3'd1;
          end
        end
        S_FIN: begin
          shifted_q <= large_shift ? '0 : acc_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
`ifdef SHL_OVF_FLAG_EN
          ovf_q     <= large_shift ? nz_q : sticky_q;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign shifted     = shifted_q;
  assign dbg_state_o = state_q;
`ifdef SHL_OVF_FLAG_EN
  assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_shl_iter.sv
// Testbench for shl_iter: vector table, random operations, and hand-written
// handshake / reset sequences, with a done-driven scoreboard.
module tb_shl_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] input1;
  logic [31:0] shift;
  logic        busy;
  logic        done;
  logic [31:0] shifted;
  logic [1:0]  dbg_state;
`ifdef SHL_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks;
  int errors;
  int cyc;
  int done_cnt;

  logic [31:0] exp_q[$];
  logic        ovf_q[$];
  int          cyc_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] exp;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[12];

  shl_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .input1      (input1),
    .shift       (shift),
    .busy        (busy),
    .done        (done),
    .shifted     (shifted),
`ifdef SHL_OVF_FLAG_EN
    .ovf         (ovf),
`endif
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: returns {ovf, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] s);
    logic [63:0] w;
    if (s >= 32) return {|a, 32'h0};
    w = {32'h0, a} << s[4:0];
    return {|w[63:32], w[31:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=%h expected=no_done", shifted);
      end else begin
        chk("shifted", shifted, exp_q.pop_front());
        chk("done_latency", cyc, cyc_q.pop_front());
`ifdef SHL_OVF_FLAG_EN
        chk("ovf", {31'h0, ovf}, {31'h0, ovf_q.pop_front()});
`else
        void'(ovf_q.pop_front());
`endif
      end
    end
  end

  // Driver: call at a negedge; returns just after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] s,
                          input logic [31:0] e, input logic eo, input bit push);
    start  = 1'b1;
    input1 = a;
    shift  = s;
    if (push) begin
      exp_q.push_back(e);
      ovf_q.push_back(eo);
      cyc_q.push_back(cyc + 7);
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    input1 = $urandom;
    shift  = $urandom;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d expected=0 pending", tag, exp_q.size());
      exp_q.delete();
      ovf_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] e, input logic eo);
    logic busy_ok;
    @(negedge clk);
    start_op(a, s, e, eo, 1'b1);
    busy_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      busy_ok &= busy;
    end
    chk("busy_6_cycles", {31'h0, busy_ok}, 32'h1);
    @(negedge clk);
    chk("busy_low_at_done", {31'h0, busy}, 32'h0);
    wait_drain("run_op");
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rs;
    int          dc;
    bit          seen;

    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    start    = 1'b0;
    input1   = '0;
    shift    = '0;
    rst_n    = 1'b0;

    tbl[0]  = '{32'h0000_0001, 32'd31,         32'h8000_0000, 1'b0};
    tbl[1]  = '{32'h1234_5678, 32'd13,         32'h8ACF_0000, 1'b1};
    tbl[2]  = '{32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 1'b1};
    tbl[3]  = '{32'hFFFF_FFFF, 32'h8000_0005,  32'h0000_0000, 1'b1};
    tbl[4]  = '{32'hA5A5_A5A5, 32'd0,          32'hA5A5_A5A5, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'd1,          32'h0000_0000, 1'b1};
    tbl[6]  = '{32'h0000_FFFF, 32'd16,         32'hFFFF_0000, 1'b0};
    tbl[7]  = '{32'h0000_FFFF, 32'd17,         32'hFFFE_0000, 1'b1};
    tbl[8]  = '{32'h0000_0003, 32'd31,         32'h8000_0000, 1'b1};
    tbl[9]  = '{32'h0000_0000, 32'd40,         32'h0000_0000, 1'b0};
    tbl[10] = '{32'h0F0F_0F0F, 32'd8,          32'h0F0F_0F00, 1'b1};
    tbl[11] = '{32'h0000_0001, 32'd5,          32'h0000_0020, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_shifted", shifted, 32'h0);
    chk("reset_state", {30'h0, dbg_state}, 32'h0);
`ifdef SHL_OVF_FLAG_EN
    chk("reset_ovf", {31'h0, ovf}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) run_op(tbl[i].a, tbl[i].s, tbl[i].exp, tbl[i].exp_ovf);

    // Random operations against the model.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 33));
      m  = model(ra, rs);
      run_op(ra, rs, m[31:0], m[32]);
    end

    // Start while busy is ignored.
    dc = done_cnt;
    @(negedge clk);
    start_op(32'h0000_00F0, 32'd4, 32'h0000_0F00, 1'b0, 1'b1);
    @(negedge clk);
    start  = 1'b1;
    input1 = 32'hFFFF_FFFF;
    shift  = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("ignored_start");
    repeat (10) @(negedge clk);
    chk("ignored_start_done_count", done_cnt - dc, 32'd1);

    // Back-to-back: start in the done cycle is accepted.
    @(negedge clk);
    start_op(32'h0000_0005, 32'd2, 32'h0000_0014, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("b2b_first_done_seen", {31'h0, seen}, 32'h1);
    if (seen) start_op(32'h0000_00FF, 32'd9, 32'h0001_FE00, 1'b0, 1'b1);
    wait_drain("back_to_back");

    // Reset in the middle of a run.
    dc = done_cnt;
    @(negedge clk);
    start_op(32'hDEAD_BEEF, 32'd4, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_busy", {31'h0, busy}, 32'h0);
    chk("midrun_shifted", shifted, 32'h0);
    chk("midrun_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrun_no_done", done_cnt - dc, 32'd0);

    // One more operation after the abandoned one.
    run_op(32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
